// File: rtl/addr_shift_reg_pkg.sv
// addr_shift_reg_pkg: shared sizing helpers for the addressable shift register
package addr_shift_reg_pkg;
  localparam int MAX_DEPTH = 128;
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction
endpackage

// File: rtl/srl_lane.sv
// srl_lane: one WIDTH-bit shift lane with a dynamic tap read and a fixed last-tap read
module srl_lane
  import addr_shift_reg_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 32,
  parameter logic [MAX_DEPTH-1:0] INIT = '0
) (
  input  logic                     sclk,
  input  logic                     ce,
  input  logic [WIDTH-1:0]         d,
  input  logic [addr_w(DEPTH)-1:0] sel,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         q_last
);
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [DEPTH-1:0] taps = INIT[DEPTH-1:0];
    // shift one bit-column; deliberately unreset so it can map onto an SRL primitive
    always_ff @(posedge sclk)
      if (ce) taps <= {taps[DEPTH-2:0], d[b]};
    assign q[b]      = taps[sel];
    assign q_last[b] = taps[DEPTH-1];
  end
endmodule

// File: rtl/addr_shift_reg.sv
// addr_shift_reg: LANES parallel addressable shift registers; SRL_FILL_EN adds a fill counter and q_valid
module addr_shift_reg
  import addr_shift_reg_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int DEPTH   = 32,
  parameter int LANES   = 1,
  parameter int NEG_CLK = 0,
  parameter logic [MAX_DEPTH-1:0] INIT = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic [LANES*WIDTH-1:0]   d,
  input  logic [addr_w(DEPTH)-1:0] addr,
  output logic [LANES*WIDTH-1:0]   q,
  output logic [LANES*WIDTH-1:0]   q_last
`ifdef SRL_FILL_EN
  ,
  output logic                     q_valid
`endif
);
  localparam int AW = addr_w(DEPTH);
  logic          sclk;
  logic [AW-1:0] sel;
  assign sclk = (NEG_CLK != 0) ? ~clk : clk;
  assign sel  = (32'(addr) >= DEPTH) ? AW'(DEPTH - 1) : addr;
  for (genvar n = 0; n < LANES; n++) begin : g_lane
    srl_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT(INIT)) u_lane (
      .sclk  (sclk),
      .ce    (ce),
      .d     (d[n*WIDTH +: WIDTH]),
      .sel   (sel),
      .q     (q[n*WIDTH +: WIDTH]),
      .q_last(q_last[n*WIDTH +: WIDTH])
    );
  end
`ifdef SRL_FILL_EN
  logic [AW:0] fill;
  // saturating count of shifts since reset; reset wins over ce
  always_ff @(posedge sclk)
    if (!rst_n) fill <= '0;
    else if (ce && fill != (AW+1)'(DEPTH)) fill <= fill + 1'b1;
  assign q_valid = fill > {1'b0, sel};
`else
  logic unused_rst_n;
  assign unused_rst_n = rst_n;
`endif
endmodule
